// File: rtl/fetch_decode_queue.sv
// Elastic fetch->decode queue: DEPTH bundles of LANES instructions, partial issue shifts the head down.
// Latency one cycle push->head; if_ready from registered count only; flush overrides push/take.
module fetch_decode_queue #(
  parameter int LANES   = 2,
  parameter int IWIDTH  = 32,
  parameter int PCWIDTH = 32,
  parameter int DEPTH   = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         if_valid,
  output logic                         if_ready,
  input  logic [PCWIDTH-1:0]           if_pc,
  input  logic [LANES*IWIDTH-1:0]      if_instr,
  input  logic [LANES-1:0]             if_lane_valid,
  output logic                         id_valid,
  output logic [PCWIDTH-1:0]           id_pc,
  output logic [LANES*IWIDTH-1:0]      id_instr,
  output logic [LANES-1:0]             id_lane_valid,
  input  logic [$clog2(LANES+1)-1:0]   id_take,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int TW = $clog2(LANES+1);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DW = LANES*IWIDTH;

  logic [PCWIDTH-1:0] r_pc    [DEPTH];
  logic [DW-1:0]      r_instr [DEPTH];
  logic [LANES-1:0]   r_mask  [DEPTH];
  logic [PW-1:0]      r_rd_ptr;
  logic [PW-1:0]      r_wr_ptr;
  logic [CW-1:0]      r_count;

  logic [PCWIDTH-1:0] w_head_pc;
  logic [DW-1:0]      w_head_instr;
  logic [LANES-1:0]   w_head_mask;
  logic [TW-1:0]      w_head_cnt;
  logic [TW-1:0]      w_eff;
  logic               w_pop;
  logic               w_part;
  logic               w_push;
  logic               w_store;
  logic [DW-1:0]      w_shift_instr;
  logic [LANES-1:0]   w_shift_mask;
  logic [PCWIDTH-1:0] w_adv_pc;
  logic [LANES-1:0]   w_mask_p1;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  assign if_ready = (r_count < CW'(DEPTH));
  assign id_valid = (r_count != '0);
  assign count    = r_count;

  // Head view is zeroed when empty so stale storage never leaks to decode.
  always_comb begin
    w_head_pc    = '0;
    w_head_instr = '0;
    w_head_mask  = '0;
    if (r_count != '0) begin
      w_head_pc    = r_pc[r_rd_ptr];
      w_head_instr = r_instr[r_rd_ptr];
      w_head_mask  = r_mask[r_rd_ptr];
    end
  end

  assign id_pc         = w_head_pc;
  assign id_instr      = w_head_instr;
  assign id_lane_valid = w_head_mask;

  always_comb begin
    w_head_cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      w_head_cnt = w_head_cnt + TW'(w_head_mask[i]);
    end
  end

  // Head count is zero when empty, so eff is zero and id_take is ignored.
  assign w_eff         = (id_take < w_head_cnt) ? id_take : w_head_cnt;
  assign w_pop         = (w_eff != '0) && (w_eff == w_head_cnt);
  assign w_part        = (w_eff != '0) && (w_eff <  w_head_cnt);
  assign w_shift_instr = w_head_instr >> (int'(w_eff) * IWIDTH);
  assign w_shift_mask  = w_head_mask >> w_eff;
  assign w_adv_pc      = w_head_pc + (PCWIDTH'(w_eff) << 2);

  assign w_push  = if_valid && if_ready && !flush;
  assign w_store = w_push && (if_lane_valid != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]    <= '0;
        r_instr[i] <= '0;
        r_mask[i]  <= '0;
      end
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      // A push never targets the head slot while it is being partially taken:
      // a partial take needs count>0 and a push needs count<DEPTH, so wr != rd.
      if (w_store) begin
        r_pc[r_wr_ptr]    <= if_pc;
        r_instr[r_wr_ptr] <= if_instr;
        r_mask[r_wr_ptr]  <= if_lane_valid;
        r_wr_ptr          <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end else if (w_part) begin
        r_pc[r_rd_ptr]    <= w_adv_pc;
        r_instr[r_rd_ptr] <= w_shift_instr;
        r_mask[r_rd_ptr]  <= w_shift_mask;
      end
      r_count <= r_count + CW'(w_store) - CW'(w_pop);
    end
  end

  assign w_mask_p1 = if_lane_valid + LANES'(1);

  a_lane_contig: assert property (@(posedge clk) disable iff (!reset)
    if_valid |-> ((if_lane_valid & w_mask_p1) == '0));

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Randomised + directed bench for fetch_decode_queue against a bundle-queue reference model.
module tb_fetch_decode_queue;

  localparam int LANES   = 2;
  localparam int IWIDTH  = 32;
  localparam int PCWIDTH = 32;
  localparam int DEPTH   = 2;

  logic                       clk;
  logic                       reset;
  logic                       flush;
  logic                       if_valid;
  logic                       if_ready;
  logic [PCWIDTH-1:0]         if_pc;
  logic [LANES*IWIDTH-1:0]    if_instr;
  logic [LANES-1:0]           if_lane_valid;
  logic                       id_valid;
  logic [PCWIDTH-1:0]         id_pc;
  logic [LANES*IWIDTH-1:0]    id_instr;
  logic [LANES-1:0]           id_lane_valid;
  logic [1:0]                 id_take;
  logic [1:0]                 count;

  fetch_decode_queue #(.LANES(LANES), .IWIDTH(IWIDTH), .PCWIDTH(PCWIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc),
    .if_instr(if_instr), .if_lane_valid(if_lane_valid),
    .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
    .id_lane_valid(id_lane_valid), .id_take(id_take), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]      pc;
    logic [1:0][31:0] lane;
    logic [7:0]       n;
  } bnd_t;

  bnd_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] mask_of(input int n);
    logic [1:0] m;
    m = '0;
    for (int i = 0; i < LANES; i++) if (i < n) m[i] = 1'b1;
    return m;
  endfunction

  task automatic model_check();
    bnd_t b;
    if (q.size() > 0) begin
      b = q[0];
      check("id_valid", 64'(id_valid), 64'd1);
      check("id_pc", 64'(id_pc), 64'(b.pc));
      check("id_instr", id_instr, 64'(b.lane));
      check("id_mask", 64'(id_lane_valid), 64'(mask_of(int'(b.n))));
    end else begin
      check("id_valid", 64'(id_valid), 64'd0);
      check("id_zero", {id_pc, id_instr[31:0]} | 64'(id_lane_valid), 64'd0);
    end
    check("count", 64'(count), 64'(q.size()));
    check("if_ready", 64'(if_ready), 64'(q.size() < DEPTH));
  endtask

  task automatic model_step(input logic v, input logic [31:0] pc, input logic [63:0] ins,
                            input logic [1:0] m, input logic [1:0] tk, input logic fl);
    bnd_t b;
    bnd_t nb;
    int   eff;
    int   n;
    bit   rdy;
    if (fl) begin
      q.delete();
      return;
    end
    rdy = (q.size() < DEPTH);
    if (q.size() > 0) begin
      b   = q[0];
      eff = (int'(tk) < int'(b.n)) ? int'(tk) : int'(b.n);
      if (eff == int'(b.n)) begin
        void'(q.pop_front());
      end else if (eff > 0) begin
        for (int i = 0; i < LANES; i++)
          b.lane[i] = (i + eff < LANES) ? b.lane[i+eff] : 32'd0;
        b.n  = b.n - 8'(eff);
        b.pc = b.pc + 32'(4 * eff);
        q[0] = b;
      end
    end
    n = 0;
    for (int i = 0; i < LANES; i++) if (m[i]) n++;
    if (v && rdy && n != 0) begin
      nb.pc   = pc;
      nb.lane = ins;
      nb.n    = 8'(n);
      q.push_back(nb);
    end
  endtask

  // One clock: drive, check registered view on the falling edge, advance model, take the edge.
  task automatic cyc(input logic v, input logic [31:0] pc, input logic [63:0] ins,
                     input logic [1:0] m, input logic [1:0] tk, input logic fl);
    if_valid = v; if_pc = pc; if_instr = ins; if_lane_valid = m; id_take = tk; flush = fl;
    @(negedge clk);
    model_check();
    model_step(v, pc, ins, m, tk, fl);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nl;
    logic [1:0] m;
    reset = 1'b0; flush = 1'b0; if_valid = 1'b0; if_pc = '0;
    if_instr = '0; if_lane_valid = '0; id_take = '0;
    #12;
    check("rst_ready", 64'(if_ready), 64'd1);
    check("rst_valid", 64'(id_valid), 64'd0);
    check("rst_out", {id_pc, id_instr[31:0]} | 64'(id_lane_valid) | 64'(count), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    cyc(1, 32'h100, {32'hBBBB_0001, 32'hAAAA_0001}, 2'b11, 0, 0);
    check("tp1_pc", 64'(id_pc), 64'h100);
    check("tp1_instr", id_instr, {32'hBBBB_0001, 32'hAAAA_0001});
    cyc(0, 0, 0, 0, 1, 0);
    check("tp2_pc", 64'(id_pc), 64'h104);
    check("tp2_instr", id_instr, {32'h0, 32'hBBBB_0001});
    check("tp2_mask", 64'(id_lane_valid), 64'h1);
    cyc(0, 0, 0, 0, 2, 0);
    check("tp2_empty", 64'({id_valid, count}), 64'h0);

    cyc(1, 32'h200, {32'h21, 32'h20}, 2'b11, 0, 0);
    cyc(1, 32'h300, {32'h31, 32'h30}, 2'b11, 0, 0);
    cyc(1, 32'h400, {32'h41, 32'h40}, 2'b11, 0, 0);
    check("tp3_full", 64'({if_ready, count}), 64'h2);
    cyc(1, 32'h400, {32'h41, 32'h40}, 2'b11, 2, 0);
    check("tp3_head", 64'(id_pc), 64'h300);
    cyc(1, 32'h400, {32'h41, 32'h40}, 2'b11, 0, 0);
    check("tp3_cnt", 64'(count), 64'd2);
    cyc(0, 0, 0, 0, 2, 0);
    check("tp3_wrap", 64'(id_pc), 64'h400);

    cyc(1, 32'h500, {32'h51, 32'h50}, 2'b11, 0, 0);
    cyc(1, 32'h600, {32'h61, 32'h60}, 2'b01, 2, 1);
    check("tp4_flush", 64'({id_valid, count}), 64'h0);
    cyc(1, 32'h700, {32'h71, 32'h70}, 2'b11, 0, 0);
    check("tp4_pc", 64'(id_pc), 64'h700);
    cyc(0, 0, 0, 0, 2, 0);

    cyc(1, 32'h800, {32'h81, 32'h80}, 2'b00, 0, 0);
    check("tp5_m0", 64'(count), 64'd0);
    cyc(1, 32'hFFFF_FFFC, {32'h91, 32'h90}, 2'b11, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    check("tp5_wrap", 64'(id_pc), 64'h0);
    cyc(0, 0, 0, 0, 1, 0);

    cyc(1, 32'hA00, {32'hA1, 32'hA0}, 2'b11, 0, 0);
    cyc(1, 32'hB00, {32'hB1, 32'hB0}, 2'b01, 0, 0);
    if_valid = 1'b0; id_take = '0; flush = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("arst_cnt", 64'(count), 64'd0);
    check("arst_out", 64'({id_valid, id_lane_valid}) | {id_pc, id_instr[31:0]}, 64'd0);
    check("arst_rdy", 64'(if_ready), 64'd1);
    q.delete();
    #1 reset = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 2000; k++) begin
      nl = $urandom_range(0, LANES);
      m  = mask_of(nl);
      cyc($urandom_range(0, 3) != 0, $urandom & 32'hFFFF_FFFC, {$urandom, $urandom}, m,
          2'($urandom_range(0, 3)), $urandom_range(0, 19) == 0);
    end
    cyc(0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_decode_queue.md
# fetch_decode_queue

Parametrised elastic pipeline stage between instruction fetch and decode in the SPU front end. It holds up to DEPTH fetch bundles of LANES instructions each, with a per-lane valid mask and bundle PC. Decode can issue fewer lanes than presented; the remaining lanes shift down and the bundle PC advances. It adds valid/ready backpressure and flush-with-priority.

## Interface
- LANES, 2, instructions per bundle (≥1)
- IWIDTH, 32, instruction width in bits
- PCWIDTH, 32, PC width in bits
- DEPTH, 2, bundle entries (≥1; need not be a power of two)

- clk  in  1  clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-low reset
- flush  in  1  discard all queued bundles (branch redirect / exception)
- if_valid  in  1  fetch presents a bundle
- if_ready  out  1  queue can accept a bundle this cycle
- if_pc  in  PCWIDTH  PC of lane 0 of the presented bundle
- if_instr  in  LANES*IWIDTH  instructions; lane 0 in bits [IWIDTH-1:0]
- if_lane_valid  in  LANES  lane valid mask; must be contiguous from bit 0
- id_valid  out  1  head bundle present
- id_pc  out  PCWIDTH  PC of current lane 0 of the head bundle
- id_instr  out  LANES*IWIDTH  head instructions, same packing as if_instr
- id_lane_valid  out  LANES  head lane mask
- id_take  in  $clog2(LANES+1)  lanes decode consumes this cycle, from lane 0
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Storage: circular buffer of DEPTH entries {pc, instr, lane_valid}. Read and write pointers wrap from DEPTH-1 to 0.
- if_ready = (count < DEPTH). It is derived from registered state only; a pop in the same cycle does not free a slot for that cycle's push.
- Push: if_valid && if_ready && flush==0.
  - If if_lane_valid==0, the bundle is accepted and discarded: the handshake completes and nothing is stored.
- id_valid = (count != 0). When id_valid==0, id_pc, id_instr and id_lane_valid are driven 0.
- Take: when id_valid==1, eff = min(id_take, popcount(id_lane_valid)). id_take is ignored when id_valid==0.
  - eff == 0: head unchanged.
  - eff == popcount(head mask): pop the head entry.
  - Otherwise, partial take:
    - head instr shifts right by eff*IWIDTH, zero-filled;
    - head mask shifts right by eff;
    - head pc advances by 4*eff, modulo 2^PCWIDTH.
- Push and take may occur in the same cycle. count = count + push - pop.
- flush==1 at an edge:
  - count becomes 0 and both pointers become 0;
  - any push or take in that cycle is dropped;
  - flush dominates all other events.
- A non-contiguous if_lane_valid is a protocol violation. Assertions must flag it; the resulting data behaviour is unspecified.

## Timing
- Reset (asynchronous, active-low): count=0, pointers=0, all storage 0.
  - Outputs during and after reset: if_ready=1, id_valid=0, id_pc=0, id_instr=0, id_lane_valid=0, count=0.
  - Reset asserted mid-operation clears immediately, without waiting for clk.
- Latency: a bundle pushed at edge N appears on id_* after edge N, one cycle. There is no combinational path from if_* to id_*.
- id_* outputs are combinational from the head entry only. There is no path from id_take to any output within the same cycle.
- A partial take at edge N presents the shifted head after edge N.
- Full (count==DEPTH): if_ready=0 for the whole cycle, even if the head pops that cycle.
- Empty: id_valid=0; a push fills the head and is visible the next cycle.

## Test plan
- Reset, then push {pc=0x100, instr=A,B, mask=11} with id_take=0 -> next cycle id_valid=1, id_pc=0x100, lane0=A, lane1=B, count=1.
- With that bundle at the head, drive id_take=1 -> next cycle id_pc=0x104, lane0=B, lane1=0, mask=01, count=1. Then id_take=2 -> saturates to 1, entry popped, count=0, id_valid=0.
- DEPTH=2: push three bundles back-to-back with id_take=0 -> third push stalls (if_ready=0 after count=2). Then take 2 on the head -> if_ready=1 one cycle later and the third bundle is accepted. FIFO order preserved across pointer wrap.
- Queue full, with flush and if_valid asserted and id_take=2 in the same cycle -> next cycle count=0, id_valid=0, nothing stored. The bundle pushed after the flush appears with its own PC.
- Push bundle with mask=00 -> handshake completes, count unchanged. Push with pc=0xFFFF_FFFC and mask=11, then take 1 -> id_pc wraps to 0x0000_0000.
- Assert reset asynchronously mid-cycle while count=2 -> count, id_valid and id_* go to 0 before the next clk edge. Operation resumes normally after reset deasserts.
